// File: rtl/input_debouncer_pkg.sv
// Shared types and constants for the input debouncer: channel FSM states and synchroniser depth.
package input_debouncer_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    COUNTING = 1'b1
  } db_state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: 2-flop synchroniser, IDLE/COUNTING FSM with stability counter,
// registered rise/fall pulses and, with DEBOUNCE_TOGGLE_EN, a push-on/push-off toggle.
module debounce_channel
  import input_debouncer_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_BITS      = $clog2(STABLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_in,
  output logic level_out,
  output logic rise_out,
  output logic fall_out,
  output logic busy_out
`ifdef DEBOUNCE_TOGGLE_EN
  ,
  output logic toggle_out
`endif
);

  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(STABLE_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  db_state_t              state_q, state_d;
  logic [CNT_BITS-1:0]    cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   busy_q, busy_d;
  logic                   synced;
  logic                   accept;

  assign synced = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], pin_in};
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (synced != level_q) begin
          // A one-cycle threshold accepts on the first mismatch without counting.
          if (STABLE_CYCLES == 1) begin
            accept = 1'b1;
          end else begin
            cnt_d   = CNT_ONE;
            state_d = COUNTING;
          end
        end
      end
      COUNTING: begin
        if (synced == level_q) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    level_d = accept ? synced : level_q;
    rise_d  = accept & synced;
    fall_d  = accept & ~synced;
    busy_d  = (state_d == COUNTING);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign level_out = level_q;
  assign rise_out  = rise_q;
  assign fall_out  = fall_q;
  assign busy_out  = busy_q;

`ifdef DEBOUNCE_TOGGLE_EN
  logic toggle_q, toggle_d;

  // Flips one cycle after each accepted press.
  always_comb toggle_d = toggle_q ^ rise_q;

  always_ff @(posedge clk) begin
    if (reset) toggle_q <= 1'b0;
    else       toggle_q <= toggle_d;
  end

  assign toggle_out = toggle_q;
`endif

endmodule

// File: rtl/input_debouncer.sv
// Multi-channel pushbutton/switch conditioner: WIDTH independent debounce channels.
// Optional DEBOUNCE_TOGGLE_EN adds a per-channel push-on/push-off toggle_out port.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_out,
  output logic [WIDTH-1:0] fall_out,
  output logic             busy_out
`ifdef DEBOUNCE_TOGGLE_EN
  ,
  output logic [WIDTH-1:0] toggle_out
`endif
);

  localparam int CNT_BITS = $clog2(STABLE_CYCLES + 1);

  logic [WIDTH-1:0] busy_vec;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .CNT_BITS     (CNT_BITS)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .pin_in    (pin_in[gi]),
      .level_out (level_out[gi]),
      .rise_out  (rise_out[gi]),
      .fall_out  (fall_out[gi]),
      .busy_out  (busy_vec[gi])
`ifdef DEBOUNCE_TOGGLE_EN
      ,
      .toggle_out(toggle_out[gi])
`endif
    );
  end

  assign busy_out = |busy_vec;

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: one instance at STABLE_CYCLES=4, one at STABLE_CYCLES=1,
// compared every cycle against a run-length reference model, plus directed boundary checks.
module tb_input_debouncer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] pin_a, pin_b;
  logic [3:0] lvl_a, rise_a, fall_a, lvl_b, rise_b, fall_b;
  logic       busy_a, busy_b;
`ifdef DEBOUNCE_TOGGLE_EN
  logic [3:0] tog_a, tog_b;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  input_debouncer #(.WIDTH(4), .STABLE_CYCLES(4)) dut_a (
    .clk(clk), .reset(rst), .pin_in(pin_a),
    .level_out(lvl_a), .rise_out(rise_a), .fall_out(fall_a), .busy_out(busy_a)
`ifdef DEBOUNCE_TOGGLE_EN
    , .toggle_out(tog_a)
`endif
  );

  input_debouncer #(.WIDTH(4), .STABLE_CYCLES(1)) dut_b (
    .clk(clk), .reset(rst), .pin_in(pin_b),
    .level_out(lvl_b), .rise_out(rise_b), .fall_out(fall_b), .busy_out(busy_b)
`ifdef DEBOUNCE_TOGGLE_EN
    , .toggle_out(tog_b)
`endif
  );

  // Reference model: per instance, a delay line for the synchroniser and, per channel,
  // the length of the current run of samples that disagree with the accepted level.
  int         s_of [2] = '{4, 1};
  logic [3:0] m_s1 [2], m_s2 [2], m_lvl [2], m_rise [2], m_fall [2], m_tog [2];
  logic       m_busy [2];
  int         m_run [2][4];

  task automatic model_edge();
    logic [3:0] pin;
    for (int i = 0; i < 2; i++) begin
      pin = (i == 0) ? pin_a : pin_b;
      if (rst) begin
        m_s1[i] = '0; m_s2[i] = '0; m_lvl[i] = '0;
        m_rise[i] = '0; m_fall[i] = '0; m_tog[i] = '0; m_busy[i] = 1'b0;
        for (int c = 0; c < 4; c++) m_run[i][c] = 0;
      end else begin
        m_tog[i]  = m_tog[i] ^ m_rise[i];
        m_rise[i] = '0;
        m_fall[i] = '0;
        m_busy[i] = 1'b0;
        for (int c = 0; c < 4; c++) begin
          if (m_s2[i][c] == m_lvl[i][c]) begin
            m_run[i][c] = 0;
          end else begin
            m_run[i][c]++;
            if (m_run[i][c] >= s_of[i]) begin
              m_lvl[i][c]  = m_s2[i][c];
              m_rise[i][c] = m_s2[i][c];
              m_fall[i][c] = ~m_s2[i][c];
              m_run[i][c]  = 0;
            end else begin
              m_busy[i] = 1'b1;
            end
          end
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = pin;
      end
    end
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic check_all();
    check("a_level", lvl_a, m_lvl[0]);
    check("a_rise", rise_a, m_rise[0]);
    check("a_fall", fall_a, m_fall[0]);
    check("a_busy", {3'b0, busy_a}, {3'b0, m_busy[0]});
    check("a_rise_and_fall", rise_a & fall_a, 4'h0);
    check("b_level", lvl_b, m_lvl[1]);
    check("b_rise", rise_b, m_rise[1]);
    check("b_fall", fall_b, m_fall[1]);
    check("b_busy", {3'b0, busy_b}, {3'b0, m_busy[1]});
`ifdef DEBOUNCE_TOGGLE_EN
    check("a_toggle", tog_a, m_tog[0]);
    check("b_toggle", tog_b, m_tog[1]);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    logic [3:0] rise_seen, fall_seen;
    logic       busy_seen;
    int         hold;

    // 1: reset with pins high, then full-latency rise on all channels
    rst = 1'b1; pin_a = 4'hF; pin_b = 4'h0;
    ticks(2);
    check("reset_level", lvl_a, 4'h0);
    check("reset_rise", rise_a, 4'h0);
    check("reset_busy", {3'b0, busy_a}, 4'h0);
    rst = 1'b0;
    ticks(5);
    check("t1_level_edge5", lvl_a, 4'h0);
    tick();
    check("t1_level_edge6", lvl_a, 4'hF);
    check("t1_rise_edge6", rise_a, 4'hF);
    tick();
    check("t1_rise_edge7", rise_a, 4'h0);
    $display("step t1 reset/initial rise: level=%h", lvl_a);

    // 2: bounce rejection on channel 0
    pin_a = 4'h0;
    ticks(7);
    check("t2_all_low", lvl_a, 4'h0);
    rise_seen = '0; fall_seen = '0; busy_seen = 1'b0;
    pin_a = 4'h1;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) pin_a = 4'h0;
      tick();
      rise_seen |= rise_a; fall_seen |= fall_a; busy_seen |= busy_a;
    end
    check("t2_busy_seen", {3'b0, busy_seen}, 4'h1);
    check("t2_no_rise", rise_seen, 4'h0);
    check("t2_no_fall", fall_seen, 4'h0);
    check("t2_level", lvl_a, 4'h0);
    $display("step t2 bounce: busy_seen=%0b level=%h", busy_seen, lvl_a);

    // 3: threshold 3 cycles rejected, 4 accepted, then fall
    rise_seen = '0;
    pin_a = 4'h2;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) pin_a = 4'h0;
      tick();
      rise_seen |= rise_a;
    end
    check("t3_short_no_rise", rise_seen, 4'h0);
    check("t3_short_level", lvl_a, 4'h0);
    pin_a = 4'h2;
    ticks(5);
    check("t3_level_edge5", lvl_a, 4'h0);
    tick();
    check("t3_level_edge6", lvl_a, 4'h2);
    check("t3_rise_edge6", rise_a, 4'h2);
    pin_a = 4'h0;
    ticks(5);
    check("t3_fall_early", fall_a, 4'h0);
    tick();
    check("t3_fall", fall_a, 4'h2);
    check("t3_fall_level", lvl_a, 4'h0);
    tick();
    check("t3_fall_done", fall_a, 4'h0);
    $display("step t3 threshold: level=%h", lvl_a);

    // 4: reset in the middle of a count
    pin_a = 4'h4;
    ticks(3);
    check("t4_busy_before", {3'b0, busy_a}, 4'h1);
    rst = 1'b1;
    tick();
    check("t4_busy_reset", {3'b0, busy_a}, 4'h0);
    check("t4_rise_reset", rise_a, 4'h0);
    rst = 1'b0;
    ticks(5);
    check("t4_level_edge5", lvl_a, 4'h0);
    tick();
    check("t4_level_edge6", lvl_a, 4'h4);
    check("t4_rise_edge6", rise_a, 4'h4);
    pin_a = 4'h0;
    ticks(8);
    $display("step t4 reset mid-count: level=%h", lvl_a);

    // 5: STABLE_CYCLES=1 single-cycle pulse on channel 3
    pin_b = 4'h8;
    tick();
    pin_b = 4'h0;
    tick();
    check("t5_level_edge2", lvl_b, 4'h0);
    tick();
    check("t5_level_edge3", lvl_b, 4'h8);
    check("t5_rise_edge3", rise_b, 4'h8);
    tick();
    check("t5_level_edge4", lvl_b, 4'h0);
    check("t5_fall_edge4", fall_b, 4'h8);
    check("t5_rise_edge4", rise_b, 4'h0);
    tick();
    check("t5_fall_edge5", fall_b, 4'h0);
    $display("step t5 single-cycle threshold: level=%h", lvl_b);

`ifdef DEBOUNCE_TOGGLE_EN
    // 6: three clean presses on channel 0 -> toggle 1,0,1
    for (int p = 0; p < 3; p++) begin
      pin_a = 4'h1;
      ticks(7);
      check("t6_toggle", tog_a & 4'h1, (p % 2 == 0) ? 4'h1 : 4'h0);
      pin_a = 4'h0;
      ticks(8);
      $display("step t6 press %0d: toggle=%h", p, tog_a);
    end
`endif

    // Randomised segments on both instances with occasional reset
    for (int s = 0; s < 60; s++) begin
      pin_a = 4'($urandom);
      pin_b = 4'($urandom);
      rst   = ($urandom_range(0, 19) == 0);
      hold  = rst ? 1 : int'($urandom_range(1, 7));
      ticks(hold);
      rst = 1'b0;
      $display("step rand %0d: pin_a=%h pin_b=%h hold=%0d level_a=%h level_b=%h",
               s, pin_a, pin_b, hold, lvl_a, lvl_b);
    end
    pin_a = 4'h0; pin_b = 4'h0;
    ticks(8);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
